// File: rtl/time_keeper.sv
// BCD hh:mm:ss time-of-day counter with a one-second prescaler, 12/24-hour modes,
// hour conversion on mode change and validated loads from the time-setting block.
module time_keeper #(
    parameter int unsigned TICKS_PER_SEC = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       mode,
    input  logic       load_en,
    input  logic [7:0] setHour,
    input  logic [7:0] setMinute,
    input  logic       setPm,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic       pm,
    output logic       sec_pulse,
    output logic       min_pulse,
    output logic       load_err
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [4:0] bcd_to_bin(input logic [7:0] v);
        return 5'(v[7:4] * 4'd10 + 5'(v[3:0]));
    endfunction

    function automatic logic [7:0] bin_to_bcd(input logic [4:0] b);
        return {4'(b / 5'd10), 4'(b % 5'd10)};
    endfunction

    logic [PW-1:0] presc, presc_n;
    logic          mode_q, mode_q_n;
    logic [7:0]    hour_n, minute_n, second_n;
    logic          pm_n, sec_pulse_n, min_pulse_n, load_err_n;
    logic          tick, digits_ok, hour_ok, load_ok;
    logic [4:0]    hour_bin;

    assign tick     = (presc == PRESC_LAST);
    assign hour_bin = bcd_to_bin(hour);

    // Nibbles are range-checked first so plain byte compares are valid BCD compares.
    assign digits_ok = (setHour[3:0] <= 4'd9) && (setHour[7:4] <= 4'd9) &&
                       (setMinute[3:0] <= 4'd9) && (setMinute <= 8'h59);
    assign hour_ok   = mode ? ((setHour >= 8'h01) && (setHour <= 8'h12)) : (setHour <= 8'h23);
    assign load_ok   = digits_ok && hour_ok;

    always_comb begin
        presc_n     = tick ? '0 : presc + PW'(1);
        mode_q_n    = mode_q;
        hour_n      = hour;
        minute_n    = minute;
        second_n    = second;
        pm_n        = pm;
        sec_pulse_n = 1'b0;
        min_pulse_n = 1'b0;
        load_err_n  = 1'b0;

        if (load_en) begin
            if (load_ok) begin
                hour_n   = setHour;
                minute_n = setMinute;
                second_n = 8'h00;
                pm_n     = mode & setPm;
                presc_n  = '0;
                mode_q_n = mode;
            end else begin
                load_err_n = 1'b1;
            end
        end else if (mode != mode_q) begin
            // Mode change: convert the stored hour; any tick this cycle is dropped.
            mode_q_n = mode;
            if (mode) begin
                if (hour_bin == 5'd0) begin
                    hour_n = 8'h12;
                    pm_n   = 1'b0;
                end else if (hour_bin < 5'd12) begin
                    pm_n   = 1'b0;
                end else if (hour_bin == 5'd12) begin
                    pm_n   = 1'b1;
                end else begin
                    hour_n = bin_to_bcd(hour_bin - 5'd12);
                    pm_n   = 1'b1;
                end
            end else begin
                if (hour == 8'h12)
                    hour_n = pm ? 8'h12 : 8'h00;
                else if (pm)
                    hour_n = bin_to_bcd(hour_bin + 5'd12);
                pm_n = 1'b0;
            end
        end else if (tick) begin
            sec_pulse_n = 1'b1;
            if (second == 8'h59) begin
                second_n    = 8'h00;
                min_pulse_n = 1'b1;
                if (minute == 8'h59) begin
                    minute_n = 8'h00;
                    if (mode_q) begin
                        if (hour == 8'h12) begin
                            hour_n = 8'h01;
                        end else begin
                            hour_n = bcd_inc(hour);
                            if (hour == 8'h11)
                                pm_n = ~pm;
                        end
                    end else begin
                        hour_n = (hour == 8'h23) ? 8'h00 : bcd_inc(hour);
                    end
                end else begin
                    minute_n = bcd_inc(minute);
                end
            end else begin
                second_n = bcd_inc(second);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc     <= '0;
            mode_q    <= 1'b0;
            hour      <= 8'h00;
            minute    <= 8'h00;
            second    <= 8'h00;
            pm        <= 1'b0;
            sec_pulse <= 1'b0;
            min_pulse <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            presc     <= presc_n;
            mode_q    <= mode_q_n;
            hour      <= hour_n;
            minute    <= minute_n;
            second    <= second_n;
            pm        <= pm_n;
            sec_pulse <= sec_pulse_n;
            min_pulse <= min_pulse_n;
            load_err  <= load_err_n;
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// Directed self-checking bench for time_keeper with TICKS_PER_SEC=4:
// a table of back-to-back loads plus hand-written tick, rollover, mode and reset sequences.
module tb_time_keeper;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       mode = 1'b0;
    logic       load_en = 1'b0;
    logic [7:0] setHour = 8'h00;
    logic [7:0] setMinute = 8'h00;
    logic       setPm = 1'b0;
    logic [7:0] hour, minute, second;
    logic       pm, sec_pulse, min_pulse, load_err;

    int errors = 0;
    int checks = 0;

    time_keeper #(.TICKS_PER_SEC(4)) dut (
        .CLK(CLK), .RST(RST), .mode(mode), .load_en(load_en),
        .setHour(setHour), .setMinute(setMinute), .setPm(setPm),
        .hour(hour), .minute(minute), .second(second), .pm(pm),
        .sec_pulse(sec_pulse), .min_pulse(min_pulse), .load_err(load_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       m;
        logic [7:0] sh;
        logic [7:0] sm;
        logic       sp;
        logic       e_err;
        logic [7:0] e_hour;
        logic [7:0] e_min;
        logic       e_pm;
    } load_vec_t;

    load_vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input logic m, input logic [7:0] h, input logic [7:0] mi, input logic p);
        mode = m; setHour = h; setMinute = mi; setPm = p; load_en = 1'b1;
        step(1);
        load_en = 1'b0;
    endtask

    task automatic chk_time(input string tag, input logic [7:0] h, input logic [7:0] mi,
                            input logic [7:0] s, input logic p);
        chk({tag, ".hour"},   32'(hour),   32'(h));
        chk({tag, ".minute"}, 32'(minute), 32'(mi));
        chk({tag, ".second"}, 32'(second), 32'(s));
        chk({tag, ".pm"},     32'(pm),     32'(p));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 8'h10, 8'h20, 1'b0, 1'b0, 8'h10, 8'h20, 1'b0};
        vecs[1]  = '{1'b0, 8'h24, 8'h00, 1'b0, 1'b1, 8'h10, 8'h20, 1'b0};
        vecs[2]  = '{1'b0, 8'h12, 8'h60, 1'b0, 1'b1, 8'h10, 8'h20, 1'b0};
        vecs[3]  = '{1'b0, 8'h1A, 8'h00, 1'b0, 1'b1, 8'h10, 8'h20, 1'b0};
        vecs[4]  = '{1'b0, 8'h10, 8'h5A, 1'b0, 1'b1, 8'h10, 8'h20, 1'b0};
        vecs[5]  = '{1'b1, 8'h12, 8'h05, 1'b1, 1'b0, 8'h12, 8'h05, 1'b1};
        vecs[6]  = '{1'b1, 8'h13, 8'h00, 1'b0, 1'b1, 8'h12, 8'h05, 1'b1};
        vecs[7]  = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h12, 8'h05, 1'b1};
        vecs[8]  = '{1'b1, 8'h07, 8'h45, 1'b0, 1'b0, 8'h07, 8'h45, 1'b0};
        vecs[9]  = '{1'b0, 8'h08, 8'h00, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 8'h23, 8'h59, 1'b1, 1'b0, 8'h23, 8'h59, 1'b0};

        // Reset state
        step(2);
        chk_time("reset", 8'h00, 8'h00, 8'h00, 1'b0);
        chk("reset.sec_pulse", 32'(sec_pulse), 0);
        chk("reset.load_err", 32'(load_err), 0);
        RST = 1'b0;

        // First second after 4 cycles, then minute rollover at tick 60
        step(4);
        chk("t1.second", 32'(second), 32'h01);
        chk("t1.sec_pulse", 32'(sec_pulse), 1);
        step(1);
        chk("t1.sec_pulse_low", 32'(sec_pulse), 0);
        step(235);
        chk_time("t1.min", 8'h00, 8'h01, 8'h00, 1'b0);
        chk("t1.min_pulse", 32'(min_pulse), 1);
        step(1);
        chk("t1.min_pulse_low", 32'(min_pulse), 0);

        // 24-hour day wrap
        do_load(1'b0, 8'h23, 8'h59, 1'b0);
        step(240);
        chk_time("t2.wrap", 8'h00, 8'h00, 8'h00, 1'b0);

        // 12-hour: 11:59 AM -> 12:00 PM, 12:59 PM -> 01:00 PM
        do_load(1'b1, 8'h11, 8'h59, 1'b0);
        chk("t3.load_pm", 32'(pm), 0);
        step(240);
        chk_time("t3.noon", 8'h12, 8'h00, 8'h00, 1'b1);
        do_load(1'b1, 8'h12, 8'h59, 1'b1);
        step(240);
        chk_time("t3.one", 8'h01, 8'h00, 8'h00, 1'b1);

        // Mode conversions
        do_load(1'b0, 8'h15, 8'h30, 1'b0);
        mode = 1'b1; step(1);
        chk_time("t4.to12", 8'h03, 8'h30, 8'h00, 1'b1);
        mode = 1'b0; step(1);
        chk_time("t4.to24", 8'h15, 8'h30, 8'h00, 1'b0);
        do_load(1'b0, 8'h00, 8'h10, 1'b0);
        mode = 1'b1; step(1);
        chk_time("t4.midnight", 8'h12, 8'h10, 8'h00, 1'b0);
        do_load(1'b1, 8'h09, 8'h00, 1'b1);
        mode = 1'b0; step(1);
        chk_time("t4.9pm", 8'h21, 8'h00, 8'h00, 1'b0);
        do_load(1'b1, 8'h12, 8'h00, 1'b1);
        mode = 1'b0; step(1);
        chk_time("t4.noon24", 8'h12, 8'h00, 8'h00, 1'b0);

        // Back-to-back load table: valid and rejected loads
        for (int i = 0; i < 11; i++) begin
            do_load(vecs[i].m, vecs[i].sh, vecs[i].sm, vecs[i].sp);
            chk($sformatf("ld%0d.err", i), 32'(load_err), 32'(vecs[i].e_err));
            chk_time($sformatf("ld%0d", i), vecs[i].e_hour, vecs[i].e_min, 8'h00, vecs[i].e_pm);
        end

        // Rejected load that also changes mode: conversion deferred to next cycle
        do_load(1'b0, 8'h14, 8'h00, 1'b0);
        do_load(1'b1, 8'h00, 8'h00, 1'b0);
        chk("t5.err", 32'(load_err), 1);
        chk_time("t5.held", 8'h14, 8'h00, 8'h00, 1'b0);
        step(1);
        chk("t5.err_low", 32'(load_err), 0);
        chk_time("t5.deferred", 8'h02, 8'h00, 8'h00, 1'b1);

        // Load coinciding with a tick wins and restarts the prescaler
        mode = 1'b0;
        do_load(1'b0, 8'h10, 8'h00, 1'b0);
        step(3);
        do_load(1'b0, 8'h05, 8'h06, 1'b0);
        chk_time("t6.load", 8'h05, 8'h06, 8'h00, 1'b0);
        chk("t6.no_pulse", 32'(sec_pulse), 0);
        step(3);
        chk("t6.second_hold", 32'(second), 0);
        step(1);
        chk("t6.second", 32'(second), 32'h01);
        chk("t6.sec_pulse", 32'(sec_pulse), 1);

        // Asynchronous reset mid-count, then release in 12-hour mode
        step(2);
        #2 RST = 1'b1;
        #1;
        chk_time("t6.rst", 8'h00, 8'h00, 8'h00, 1'b0);
        chk("t6.rst_pulse", 32'(sec_pulse), 0);
        mode = 1'b1;
        step(1);
        RST = 1'b0;
        step(1);
        chk_time("t6.rst12", 8'h12, 8'h00, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
